lab1_sys_pio_debounce_in: RTL and testbench

Parametrised Avalon-MM input PIO for push-buttons and switches in `lab1_sys`: WIDTH input channels, each with a two-flop synchroniser and a per-channel debounce counter. Programmable per-channel rising/falling edge capture feeds a level IRQ to the Nios II interrupt controller. It sits on the system interconnect as an `s1` slave in place of the fixed 8-bit any-edge input PIO. It also exposes the raw synchronised inputs for diagnostics.

---
 rtl/lab1_sys_pio_debounce_in.sv | 109 ++++++++++
 tb/tb_lab1_sys_pio_debounce_in.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lab1_sys_pio_debounce_in.sv
// Avalon-MM input PIO: per-channel two-flop synchroniser, debounce counter,
// programmable rise/fall edge capture and a level IRQ built from registers only.
module lab1_sys_pio_debounce_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [WIDTH-1:0]       r_sync1;
    logic [WIDTH-1:0]       r_sync2;
    logic [WIDTH-1:0]       r_stable;
    logic [WIDTH*CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]       r_edge_cap;
    logic [WIDTH-1:0]       r_irq_mask;
    logic [WIDTH-1:0]       r_rise_en;
    logic [WIDTH-1:0]       r_fall_en;
    logic [31:0]            r_readdata;

    logic [WIDTH*CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0]       w_update;
    logic [WIDTH-1:0]       w_capture;
    logic [WIDTH-1:0]       w_wdata;
    logic                   w_wr;
    logic [31:0]            w_rd_mux;
    logic                   w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    // Each channel counts consecutive cycles that sync2 disagrees with the
    // accepted level; any agreement (a bounce back) restarts the count.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic             w_differ;
            logic             w_at_limit;
            logic [CNT_W-1:0] w_cnt;

            assign w_cnt      = r_cnt[gi*CNT_W +: CNT_W];
            assign w_differ   = r_sync2[gi] ^ r_stable[gi];
            assign w_at_limit = (w_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
            assign w_update[gi] = w_differ & w_at_limit;
            assign w_cnt_next[gi*CNT_W +: CNT_W] =
                (!w_differ || w_at_limit) ? '0 : w_cnt + CNT_W'(1);
            assign w_capture[gi] =
                (w_update[gi] &  r_sync2[gi] & r_rise_en[gi]) |
                (w_update[gi] & ~r_sync2[gi] & r_fall_en[gi]);
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        case (address)
            3'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
            3'd1:    w_rd_mux[WIDTH-1:0] = r_sync2;
            3'd2:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
            3'd3:    w_rd_mux[WIDTH-1:0] = r_edge_cap;
            3'd4:    w_rd_mux[WIDTH-1:0] = r_rise_en;
            3'd5:    w_rd_mux[WIDTH-1:0] = r_fall_en;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_cnt      <= '0;
            r_edge_cap <= '0;
            r_irq_mask <= '0;
            r_rise_en  <= '1;
            r_fall_en  <= '1;
            r_readdata <= '0;
        end else begin
            r_sync1    <= in_port;
            r_sync2    <= r_sync1;
            // An update only fires when sync2 differs, so flipping is the new level.
            r_stable   <= r_stable ^ w_update;
            r_cnt      <= w_cnt_next;
            r_readdata <= w_rd_mux;

            // Capture is OR-ed after the clear so a coincident event survives.
            if (w_wr && address == 3'd3)
                r_edge_cap <= (r_edge_cap & ~w_wdata) | w_capture;
            else
                r_edge_cap <= r_edge_cap | w_capture;

            if (w_wr && address == 3'd2) r_irq_mask <= w_wdata;
            if (w_wr && address == 3'd4) r_rise_en  <= w_wdata;
            if (w_wr && address == 3'd5) r_fall_en  <= w_wdata;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_lab1_sys_pio_debounce_in.sv
// Directed bench for lab1_sys_pio_debounce_in (WIDTH=8, DEBOUNCE_CYCLES=16).
// Inputs change on the falling edge and outputs are sampled there too.
module tb_lab1_sys_pio_debounce_in;
    localparam int WIDTH = 8;
    localparam int DEB   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  in_port;
    logic              irq;

    int n_total = 0;
    int n_bad   = 0;

    lab1_sys_pio_debounce_in #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] d;
    logic [31:0] exp_rst [8];

    initial begin
        exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'hFF, 32'h0, 32'h0};
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        @(negedge clk);
        hold(3);
        reset = 1'b0;

        // Reset state of the whole register map
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            check($sformatf("rst_addr%0d", i), d, exp_rst[i]);
        end
        check("rst_irq", {31'b0, irq}, 32'd0);

        // Bounce filter: 10 high, 3 low, then high; accept exactly 18 edges after
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        hold(10);
        in_port = 8'h00;
        hold(3);
        in_port = 8'h01;
        hold(17);
        check("bounce_irq_edge17", {31'b0, irq}, 32'd0);
        hold(1);
        check("bounce_irq_edge18", {31'b0, irq}, 32'd1);
        rd(3'd3, d);
        check("bounce_cap", d, 32'h01);
        rd(3'd0, d);
        check("bounce_data", d, 32'h01);
        wr(3'd3, 32'h01);
        check("bounce_clr_irq", {31'b0, irq}, 32'd0);

        // Edge modes: ch0 rise only, ch1 fall only
        in_port = 8'h00;
        hold(30);
        wr(3'd3, 32'hFF);
        wr(3'd4, 32'h01);
        wr(3'd5, 32'h02);
        wr(3'd2, 32'h03);
        rd(3'd3, d);
        check("mode_cap_init", d, 32'h00);
        in_port = 8'h01;
        hold(30);
        rd(3'd3, d);
        check("mode_ch0_rise", d, 32'h01);
        check("mode_irq", {31'b0, irq}, 32'd1);
        in_port = 8'h00;
        hold(30);
        rd(3'd3, d);
        check("mode_ch0_fall", d, 32'h01);
        in_port = 8'h02;
        hold(30);
        rd(3'd3, d);
        check("mode_ch1_rise", d, 32'h01);
        in_port = 8'h00;
        hold(30);
        rd(3'd3, d);
        check("mode_ch1_fall", d, 32'h03);

        // Write-1-clear
        wr(3'd3, 32'hFF);
        wr(3'd4, 32'h05);
        in_port = 8'h05;
        hold(30);
        rd(3'd3, d);
        check("w1c_cap_05", d, 32'h05);
        wr(3'd2, 32'h01);
        wr(3'd3, 32'h04);
        rd(3'd3, d);
        check("w1c_cap_01", d, 32'h01);
        check("w1c_irq_kept", {31'b0, irq}, 32'd1);
        wr(3'd3, 32'h01);
        check("w1c_irq_drop", {31'b0, irq}, 32'd0);

        // Capture and clear of ch2 on the same edge: capture wins
        wr(3'd5, 32'h04);
        in_port = 8'h01;
        hold(17);
        wr(3'd3, 32'h04);
        rd(3'd3, d);
        check("simul_cap", d, 32'h04);

        // Reset pulse mid-debounce restarts every counter
        in_port = 8'hFF;
        address = 3'd0;
        hold(10);
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        check("midrst_rdata", readdata, 32'h00);
        check("midrst_irq", {31'b0, irq}, 32'd0);
        hold(18);
        check("midrst_data_edge18", readdata, 32'h00);
        hold(1);
        check("midrst_data_edge19", readdata, 32'hFF);
        rd(3'd3, d);
        check("midrst_cap", d, 32'hFF);
        rd(3'd4, d);
        check("midrst_rise_en", d, 32'hFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
